// File: rtl/xoodoo_perm_arbiter.sv
// rtl/xoodoo_perm_arbiter.sv - two-requester round-robin arbiter and round sequencer for a shared Xoodoo round
//
// Purpose: grants one of two requesters and captures its 384-bit state in the work register.
//          Steps an external combinational Xoodoo round through NROUNDS rounds, one per cycle,
//          then returns the permuted state with a done pulse for the requester that was granted.
// Ports:
//   i_clk, i_resetn               clock, synchronous active-low reset
//   i_req0/1, i_state0/1_in       permutation requests and their input states
//   o_gnt0/1                      one-cycle grant pulses (first RUN cycle)
//   o_done0/1                     one-cycle completion pulses; o_result is valid in that cycle
//   o_result                      permuted state, held until the next completion
//   o_busy                        high while a job is in RUN or DONE
//   o_rnd_state_out, o_rnd_idx    work register and round-constant index driven to the round logic
//   i_rnd_state_in                one-round output of the external round logic

module xoodoo_perm_arbiter #(
    parameter int NROUNDS = 12
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_req0,
    input  logic [383:0] i_state0_in,
    input  logic         i_req1,
    input  logic [383:0] i_state1_in,
    output logic         o_gnt0,
    output logic         o_gnt1,
    output logic         o_done0,
    output logic         o_done1,
    output logic [383:0] o_result,
    output logic         o_busy,
    output logic [383:0] o_rnd_state_out,
    output logic [3:0]   o_rnd_idx,
    input  logic [383:0] i_rnd_state_in
);

    // A reduced-round permutation uses the tail of the 12-entry constant table.
    localparam logic [3:0] START_IDX = 4'(12 - NROUNDS);
    localparam logic [3:0] LAST_IDX  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [383:0] r_work;
    logic [383:0] r_result;
    logic [3:0]   r_idx;
    logic         r_last;
    logic         r_owner;
    logic         r_gnt0;
    logic         r_gnt1;

    logic         w_grant;
    logic         w_pick1;
    logic         w_finish;

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_pick1      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    w_grant      = 1'b1;
                    // Under contention the requester not served last wins.
                    w_pick1      = i_req1 && (!i_req0 || !r_last);
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_finish     = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_gnt0  <= w_grant && !w_pick1;
            r_gnt1  <= w_grant && w_pick1;
            if (w_grant) begin
                r_work  <= w_pick1 ? i_state1_in : i_state0_in;
                r_idx   <= START_IDX;
                r_last  <= w_pick1;
                r_owner <= w_pick1;
            end
            if (r_state == S_RUN) begin
                r_work <= i_rnd_state_in;
                // The index saturates at the last round and is held afterwards.
                if (!w_finish) begin
                    r_idx <= r_idx + 4'd1;
                end else begin
                    r_result <= i_rnd_state_in;
                end
            end
        end
    end

    assign o_gnt0          = r_gnt0;
    assign o_gnt1          = r_gnt1;
    assign o_done0         = (r_state == S_DONE) && !r_owner;
    assign o_done1         = (r_state == S_DONE) && r_owner;
    assign o_busy          = (r_state != S_IDLE);
    assign o_result        = r_result;
    assign o_rnd_state_out = r_work;
    assign o_rnd_idx       = r_idx;

endmodule

// File: doc/xoodoo_perm_arbiter.md
# xoodoo_perm_arbiter

Round-robin arbiter and round sequencer that shares one combinational Xoodoo round datapath between two requesters, for example the hash engine and a keyed/AEAD engine. It grants one requester at a time and captures its 384-bit state. It then steps the external round logic through NROUNDS rounds, one per cycle, feeding the matching round-constant index. At the end it returns the permuted state with a per-requester done pulse.

## Interface
- NROUNDS, 12: rounds per permutation; legal range 1..12.
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous reset, active-low.
- req0  in  1  requester 0 wants a permutation; held high until gnt0.
- state0_in  in  384  requester 0 input state; sampled on the granting edge.
- req1  in  1  requester 1 request; same rules as req0.
- state1_in  in  384  requester 1 input state.
- gnt0 / gnt1  out  1 each  one-cycle grant pulse.
- done0 / done1  out  1 each  one-cycle completion pulse; result is valid in that cycle.
- result  out  384  permuted state; holds until the next completion.
- busy  out  1  high in RUN and DONE.
- rnd_state_out  out  384  state presented to the external round logic; this is the internal work register.
- rnd_idx  out  4  round-constant index for the external round logic; index 0 selects 0x058, 11 selects 0x012.
- rnd_state_in  in  384  one-round output of the external round logic; combinational from rnd_state_out and rnd_idx.

## Operation
- Bit ordering of all 384-bit buses matches the XOODYAK state_register: plane 0 lane 0 byte 0 sits at [7:0].
- FSM states: IDLE, RUN, DONE.
  - IDLE: if any req is high, pick a winner, load the work register from its state_in, set rnd_idx to 12-NROUNDS, pulse its gnt, and go to RUN.
  - RUN: each cycle, work register <= rnd_state_in and rnd_idx <= rnd_idx+1. When rnd_idx==11, load result from rnd_state_in and go to DONE.
  - DONE: pulse done of the granted requester; next state is IDLE.
- Arbitration:
  - A `last` pointer records which requester was served last; reset value is 1, so requester 0 wins first.
  - With only one req high, that requester wins.
  - With both high, the requester not equal to `last` wins.
  - `last` updates on grant.
- Requests are sampled only in IDLE. A req that drops before its grant is withdrawn and never served.
- req is not sampled in RUN/DONE. A requester still high when IDLE is re-entered is considered again. A requester must drop req on its gnt unless it wants another permutation.
- rnd_idx is a 4-bit counter with no wrap: it stops at 11 and is held in DONE and IDLE.
- Reset (resetn=0 at an edge), including mid-RUN, has the following effect:
  - The operation is abandoned and the FSM goes to IDLE.
  - gnt0, gnt1, done0, done1, busy, result, rnd_state_out, rnd_idx are all 0, and `last`=1.
  - No done pulse is issued for the aborted job.

## Timing
- Count cycle 0 as an IDLE cycle with req high. Then:
  - gnt high in cycle 1, and the work register holds the captured state.
  - RUN occupies cycles 1..NROUNDS.
  - done and result are valid in cycle NROUNDS+1.
  - IDLE in cycle NROUNDS+2.
  - The earliest next gnt is cycle NROUNDS+3.
- Latency from req to done is NROUNDS+1 cycles. Throughput is one permutation per NROUNDS+2 cycles.
- rnd_idx in cycle k of RUN (k=1..NROUNDS) equals 12-NROUNDS+k-1.
- gnt and done are mutually exclusive, and never high for both requesters at once.
- busy rises in cycle 1 and falls after cycle NROUNDS+1.
- The external round path is a single-cycle combinational path and must close timing within one clock.

## Test plan
- Reset check: hold resetn=0 for 3 cycles with req0=req1=1 -> every output is 0, and no gnt follows while reset is held.
- Single request, NROUNDS=12: req0=1 with state0_in=0 at cycle 0 -> gnt0 in cycle 1, rnd_idx runs 0..11 over cycles 1..12, done0 in cycle 13. result equals the bench Xoodoo[12] model applied to the zero state. busy is high in cycles 1..13.
- Contention after reset: req0 and req1 rise together and each drops on its gnt -> gnt0 in cycle 1, done0 in cycle 13, gnt1 in cycle 15, done1 in cycle 27. Each result matches its own input's model.
- Fairness: both reqs held high permanently -> grants alternate 0,1,0,1 over 4 jobs, with 14 cycles between grants.
- Reduced rounds, NROUNDS=6: req1=1 -> rnd_idx runs 6..11, done1 in cycle 7, result equals the model Xoodoo[6].
- Abort and withdraw:
  - Assert resetn=0 in cycle 5 of a RUN -> no done, all outputs 0. After release, a new req0 is granted one cycle later.
  - Separately, pulse req1 for one cycle during RUN and drop it before IDLE -> no gnt1 is ever issued.
